// File: rtl/baud_pkg.sv
// Shared defaults for the UART/SPART baud-rate generator.
// The presets assume a 50 MHz clock with 16x oversampling.
package baud_pkg;

    localparam int DEF_DIV_W      = 16;
    localparam int DEF_OVERSAMPLE = 16;

    // Sample-tick divisors for 2400 / 4800 / 9600 / 19200 baud.
    localparam int unsigned PRESET_2400  = 1302;
    localparam int unsigned PRESET_4800  = 651;
    localparam int unsigned PRESET_9600  = 326;
    localparam int unsigned PRESET_19200 = 163;

    typedef logic [DEF_DIV_W-1:0] div_t;

endpackage

// File: rtl/baud_div_regs.sv
// Custom-divisor staging and commit registers plus the preset mux.
// The d_eff output is the divisor in effect, never below 1.
module baud_div_regs
    import baud_pkg::*;
#(
    parameter int          DIV_W   = DEF_DIV_W,
    parameter int unsigned PRESET0 = PRESET_2400,
    parameter int unsigned PRESET1 = PRESET_4800,
    parameter int unsigned PRESET2 = PRESET_9600,
    parameter int unsigned PRESET3 = PRESET_19200
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       br_cfg,
    input  logic             use_custom,
    input  logic             div_wr_lo,
    input  logic             div_wr_hi,
    input  logic [7:0]       div_data,
    output logic [DIV_W-1:0] d_eff
);

    logic [7:0]       stage_lo;
    logic [DIV_W-1:0] custom_div;
    logic [DIV_W-1:0] preset_div;
    logic [DIV_W-1:0] raw_div;
    logic [15:0]      commit_word;

    // A commit always takes the low byte staged before this cycle.
    assign commit_word = {div_data, stage_lo};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_lo   <= 8'd0;
            custom_div <= '0;
        end else begin
            if (div_wr_lo) stage_lo <= div_data;
            if (div_wr_hi) custom_div <= DIV_W'(commit_word);
        end
    end

    always_comb begin
        preset_div = DIV_W'(PRESET0);
        unique case (br_cfg)
            2'b00: preset_div = DIV_W'(PRESET0);
            2'b01: preset_div = DIV_W'(PRESET1);
            2'b10: preset_div = DIV_W'(PRESET2);
            2'b11: preset_div = DIV_W'(PRESET3);
            default: preset_div = DIV_W'(PRESET0);
        endcase
        raw_div = use_custom ? custom_div : preset_div;
        d_eff   = (raw_div == '0) ? DIV_W'(1) : raw_div;
    end

endmodule

// File: rtl/baud_rate_gen.sv
// Baud-rate generator: oversample tick, per-bit tick and sub-bit phase
// from a preset or byte-programmed divisor.
module baud_rate_gen
    import baud_pkg::*;
#(
    parameter int          DIV_W      = DEF_DIV_W,
    parameter int          OVERSAMPLE = DEF_OVERSAMPLE,
    parameter int unsigned PRESET0    = PRESET_2400,
    parameter int unsigned PRESET1    = PRESET_4800,
    parameter int unsigned PRESET2    = PRESET_9600,
    parameter int unsigned PRESET3    = PRESET_19200,
    localparam int         PW         = $clog2(OVERSAMPLE)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          restart,
    input  logic [1:0]    br_cfg,
    input  logic          use_custom,
    input  logic          div_wr_lo,
    input  logic          div_wr_hi,
    input  logic [7:0]    div_data,
    output logic          sample_tick,
    output logic          baud_tick,
    output logic [PW-1:0] phase
);

    logic [DIV_W-1:0] d_eff;
    logic [DIV_W-1:0] cnt;

    baud_div_regs #(
        .DIV_W   (DIV_W),
        .PRESET0 (PRESET0),
        .PRESET1 (PRESET1),
        .PRESET2 (PRESET2),
        .PRESET3 (PRESET3)
    ) u_div_regs (
        .clk        (clk),
        .rst_n      (rst_n),
        .br_cfg     (br_cfg),
        .use_custom (use_custom),
        .div_wr_lo  (div_wr_lo),
        .div_wr_hi  (div_wr_hi),
        .div_data   (div_data),
        .d_eff      (d_eff)
    );

    // The divisor is only sampled at reload or restart, so a change never
    // shortens the period already in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            phase       <= '0;
            sample_tick <= 1'b0;
            baud_tick   <= 1'b0;
        end else if (restart) begin
            cnt         <= d_eff - 1'b1;
            phase       <= '0;
            sample_tick <= 1'b0;
            baud_tick   <= 1'b0;
        end else if (en) begin
            if (cnt == '0) begin
                cnt         <= d_eff - 1'b1;
                sample_tick <= 1'b1;
                baud_tick   <= (phase == PW'(OVERSAMPLE - 1));
                phase       <= phase + 1'b1;
            end else begin
                cnt         <= cnt - 1'b1;
                sample_tick <= 1'b0;
                baud_tick   <= 1'b0;
            end
        end else begin
            sample_tick <= 1'b0;
            baud_tick   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_baud_rate_gen.sv
// Directed bench for baud_rate_gen with a deadline-based reference model
// compared every cycle, plus literal interval checks.
module tb_baud_rate_gen;

    localparam int OS  = 16;
    localparam int LIM = 6000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       restart;
    logic [1:0] br_cfg;
    logic       use_custom;
    logic       div_wr_lo;
    logic       div_wr_hi;
    logic [7:0] div_data;
    logic       sample_tick;
    logic       baud_tick;
    logic [3:0] phase;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    baud_rate_gen dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .restart     (restart),
        .br_cfg      (br_cfg),
        .use_custom  (use_custom),
        .div_wr_lo   (div_wr_lo),
        .div_wr_hi   (div_wr_hi),
        .div_data    (div_data),
        .sample_tick (sample_tick),
        .baud_tick   (baud_tick),
        .phase       (phase)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: the next reload is a deadline in edge numbers,
    // pushed out by one for every disabled edge.
    int   m_due;
    bit   m_due_valid;
    int   m_idx;
    bit   m_st, m_bt;
    int   m_stage, m_custom;

    function automatic int eff_div(input bit uc, input logic [1:0] cfg, input int cust);
        int d;
        case (cfg)
            2'd0: d = 1302;
            2'd1: d = 651;
            2'd2: d = 326;
            default: d = 163;
        endcase
        if (uc) d = cust;
        return (d == 0) ? 1 : d;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        int d;
        int n;
        if (!rst_n) begin
            m_due_valid = 0;
            m_due       = 0;
            m_idx       = 0;
            m_st        = 0;
            m_bt        = 0;
            m_stage     = 0;
            m_custom    = 0;
        end else begin
            n = cyc;
            d = eff_div(use_custom, br_cfg, m_custom);
            if (restart) begin
                m_due = n + d; m_due_valid = 1; m_idx = 0; m_st = 0; m_bt = 0;
            end else if (en) begin
                if (!m_due_valid || n == m_due) begin
                    m_idx = (m_idx + 1) % OS;
                    m_st  = 1;
                    m_bt  = (m_idx == 0);
                    m_due = n + d; m_due_valid = 1;
                end else begin
                    m_st = 0; m_bt = 0;
                end
            end else begin
                m_st = 0; m_bt = 0;
                if (m_due_valid) m_due = m_due + 1;
            end
            if (div_wr_hi) m_custom = (int'(div_data) << 8) | m_stage;
            if (div_wr_lo) m_stage = int'(div_data);
        end
    end

    always @(negedge clk) begin
        chk("model_sample_tick", int'(sample_tick), int'(m_st));
        chk("model_baud_tick",   int'(baud_tick),   int'(m_bt));
        chk("model_phase",       int'(phase),       m_idx);
    end

    task automatic wait_tick(output int t);
        bit found = 0;
        t = -1;
        for (int i = 0; i < LIM && !found; i++) begin
            @(negedge clk);
            if (sample_tick === 1'b1) begin found = 1; t = cyc; end
        end
        if (!found) chk("sample_tick_timeout", 0, 1);
    endtask

    task automatic wait_baud(output int t);
        bit found = 0;
        t = -1;
        for (int i = 0; i < LIM && !found; i++) begin
            @(negedge clk);
            if (baud_tick === 1'b1) begin found = 1; t = cyc; end
        end
        if (!found) chk("baud_tick_timeout", 0, 1);
    endtask

    initial begin
        int c, t1, t2, b1, b2, r;
        rst_n = 0; en = 0; restart = 0; br_cfg = 2'b10; use_custom = 0;
        div_wr_lo = 0; div_wr_hi = 0; div_data = 8'd0;
        repeat (3) @(negedge clk);
        chk("reset_sample_tick", int'(sample_tick), 0);
        chk("reset_baud_tick",   int'(baud_tick),   0);
        chk("reset_phase",       int'(phase),       0);

        // Preset 9600: D=326
        en = 1; rst_n = 1; c = cyc;
        wait_tick(t1); chk("first_tick_after_reset", t1 - c, 1);
        wait_tick(t2); chk("preset_sample_period", t2 - t1, 326);
        wait_baud(b1); chk("phase_at_baud", int'(phase), 0);
        wait_baud(b2); chk("preset_baud_period", b2 - b1, 5216);

        // Custom D=4 then restart
        div_data = 8'h04; div_wr_lo = 1;
        @(negedge clk); div_wr_lo = 0; div_data = 8'h00; div_wr_hi = 1;
        @(negedge clk); div_wr_hi = 0; use_custom = 1; restart = 1; c = cyc;
        @(negedge clk); restart = 0;
        wait_tick(t1); chk("restart_first_tick", t1 - c, 5);
        wait_tick(t2); chk("custom4_period", t2 - t1, 4);
        wait_baud(b1); chk("restart_to_baud", b1 - c, 65);

        // Commit D=8 mid-period
        wait_tick(t1);
        div_data = 8'h08; div_wr_lo = 1;
        @(negedge clk); div_wr_lo = 0; div_data = 8'h00; div_wr_hi = 1;
        @(negedge clk); div_wr_hi = 0;
        wait_tick(t2); chk("inflight_period_kept", t2 - t1, 4);
        wait_tick(t1); chk("new_period_8", t1 - t2, 8);

        // Simultaneous lo/hi: commits old low byte (8), stages 0
        div_data = 8'h00; div_wr_lo = 1; div_wr_hi = 1;
        @(negedge clk); div_wr_lo = 0; div_wr_hi = 0;
        wait_tick(t1); wait_tick(t2); chk("same_cycle_commit_period", t2 - t1, 8);

        // Restart on the reload cycle
        repeat (7) @(negedge clk);
        restart = 1; r = cyc;
        @(negedge clk); restart = 0;
        chk("restart_suppress_tick", int'(sample_tick), 0);
        chk("restart_phase_clear",   int'(phase), 0);
        wait_tick(t1); chk("restart_coincident_next", t1 - r, 9);

        // Drop en for 10 cycles mid-period
        wait_tick(c);
        @(negedge clk); en = 0;
        repeat (10) @(negedge clk);
        en = 1;
        wait_tick(t1); chk("en_stretch_period", t1 - c, 18);

        // Custom D=0 (treated as 1)
        div_data = 8'h00; div_wr_hi = 1;
        @(negedge clk); div_wr_hi = 0; restart = 1;
        @(negedge clk); restart = 0;
        wait_tick(t1); wait_tick(t2); chk("d0_period", t2 - t1, 1);
        wait_baud(b1); wait_baud(b2); chk("d0_baud_period", b2 - b1, 16);

        // Custom D=1
        div_data = 8'h01; div_wr_lo = 1;
        @(negedge clk); div_wr_lo = 0; div_data = 8'h00; div_wr_hi = 1;
        @(negedge clk); div_wr_hi = 0;
        wait_baud(b1); wait_baud(b2); chk("d1_baud_period", b2 - b1, 16);
        @(negedge clk); chk("d1_continuous_tick", int'(sample_tick), 1);

        // Asynchronous reset mid-cycle
        @(posedge clk); #2; rst_n = 0; #1;
        chk("async_rst_sample_tick", int'(sample_tick), 0);
        chk("async_rst_baud_tick",   int'(baud_tick),   0);
        chk("async_rst_phase",       int'(phase),       0);
        @(negedge clk); en = 0; rst_n = 1;
        repeat (3) @(negedge clk);
        chk("post_reset_idle", int'(sample_tick), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
